// File: rtl/cmd_seq_mc_pkg.sv
// Register map, version code and FSM encoding shared by the multi-channel command sequencer.
package cmd_seq_mc_pkg;
   localparam logic [7:0] VERSION = 8'd2;

   localparam int REG_RST     = 0;
   localparam int REG_START   = 1;
   localparam int REG_CONF    = 2;
   localparam int REG_SIZE0   = 3;
   localparam int REG_SIZE1   = 4;
   localparam int REG_REP0    = 5;
   localparam int REG_REP1    = 6;
   localparam int REG_REP2    = 7;
   localparam int REG_REP3    = 8;
   localparam int REG_LSTART0 = 9;
   localparam int REG_LSTART1 = 10;
   localparam int REG_LSTOP0  = 11;
   localparam int REG_LSTOP1  = 12;
   localparam int REG_OUT_EN  = 13;
   localparam int REG_IDLE    = 14;
   localparam int REG_ABORT   = 15;
   localparam int MEM_BASE    = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RUN   = 2'd2
   } state_t;
endpackage

// File: rtl/cmd_seq_mc_out.sv
// Output stage: holds the current step, toggles the Manchester half-phase, applies lane mask and idle level.
module cmd_seq_mc_out #(
   parameter int CHANNELS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                load,
   input  logic                load_vld,
   input  logic                mode,
   input  logic [CHANNELS-1:0] data,
   input  logic [CHANNELS-1:0] out_en,
   input  logic [CHANNELS-1:0] idle_level,
   output logic [CHANNELS-1:0] lanes,
   output logic                active,
   output logic                phase
);
   logic [CHANNELS-1:0] step;
   logic [CHANNELS-1:0] coded;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step   <= '0;
         active <= 1'b0;
         phase  <= 1'b0;
      end else if (clr) begin
         active <= 1'b0;
         phase  <= 1'b0;
      end else if (load) begin
         step   <= data;
         active <= load_vld;
         phase  <= 1'b0;
      end else if (active && mode) begin
         phase  <= ~phase;
      end
   end

   // Manchester: first half carries the inverted bit, second half the bit itself.
   assign coded = (mode && !phase) ? ~step : step;
   assign lanes = active ? ((coded & out_en) | (idle_level & ~out_en)) : idle_level;
endmodule

// File: rtl/cmd_seq_mc_core.sv
// Multi-channel command sequencer: bus registers, pattern RAM, prefetching step sequencer with loop/repeat.
module cmd_seq_mc_core
   import cmd_seq_mc_pkg::*;
#(
   parameter int ABUSWIDTH = 16,
   parameter int CHANNELS  = 4,
   parameter int MEM_DEPTH = 2048
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST_N,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   input  logic [7:0]           BUS_DATA_IN,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   output logic [7:0]           BUS_DATA_OUT,
   input  logic                 CMD_EXT_START,
   input  logic                 CMD_ABORT,
   output logic [CHANNELS-1:0]  CMD_DATA,
   output logic                 CMD_READY,
   output logic                 CMD_START_FLAG,
   output logic                 CMD_LOOP_FLAG,
   output logic                 CMD_EXT_START_ENABLE,
   output state_t               dbg_state
);
   localparam int AW = $clog2(MEM_DEPTH);

   // Bus handshake: BUS_WR/BUS_RD are single-cycle strobes qualified by BUS_ADD; there is no back-pressure,
   // a write takes effect at that edge and read data is presented on BUS_DATA_OUT the cycle after BUS_RD.
   state_t state, state_n;
   logic [7:0]  conf, out_en, idle_level, reg_val, reg_rd, mem_rd;
   logic [15:0] size, loop_start, loop_stop, size_s, lstart_s, lstop_s, pos;
   logic [31:0] repeat_n, rep_s, pass;
   logic [CHANNELS-1:0] out_en_s, rd_data;
   logic [7:0]  mem [MEM_DEPTH];
   logic [ABUSWIDTH-1:0] mem_off;
   logic done, mode_s, fetch_done, rd_vld, rd_loop, rd_sel_mem;
   logic rst, start_req, abort, start_ok, load, fetch_en, loop_ok, wrap, in_mem;
   logic out_active, out_phase;

   assign rst       = !BUS_RST_N || (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_RST));
   assign start_req = (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_START)) || (CMD_EXT_START && conf[0]);
   assign abort     = CMD_ABORT || (BUS_WR && BUS_ADD == ABUSWIDTH'(REG_ABORT));
   assign start_ok  = (state == ST_IDLE) && start_req && (size != 16'd0) && !abort;
   assign load      = (state == ST_RUN) && (!out_active || !mode_s || out_phase);
   assign fetch_en  = (state == ST_FETCH) || load;
   assign loop_ok   = (lstop_s > lstart_s) && (lstop_s <= size_s);
   assign wrap      = loop_ok && (pos == lstop_s - 16'd1) && ((rep_s == 32'd0) || (pass + 32'd1 < rep_s));
   assign mem_off   = BUS_ADD - ABUSWIDTH'(MEM_BASE);
   assign in_mem    = (BUS_ADD >= ABUSWIDTH'(MEM_BASE)) && (mem_off < ABUSWIDTH'(MEM_DEPTH));

   always_ff @(posedge BUS_CLK) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:  if (start_ok) state_n = ST_FETCH;
         ST_FETCH: state_n = ST_RUN;
         ST_RUN:   if (load && !rd_vld) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
      if (abort) state_n = ST_IDLE;
   end

   // Pattern RAM: one bus write port, a prefetch read port and a bus read port; not cleared by reset.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_WR && in_mem) mem[mem_off[AW-1:0]] <= BUS_DATA_IN;
      if (fetch_en && !fetch_done) rd_data <= mem[pos[AW-1:0]][CHANNELS-1:0];
      if (BUS_RD) mem_rd <= mem[mem_off[AW-1:0]];
   end

   always_comb begin
      reg_val = 8'd0;
      case (BUS_ADD)
         ABUSWIDTH'(REG_RST):     reg_val = VERSION;
         ABUSWIDTH'(REG_START):   reg_val = {6'b0, state != ST_IDLE, done};
         ABUSWIDTH'(REG_CONF):    reg_val = conf;
         ABUSWIDTH'(REG_SIZE0):   reg_val = size[7:0];
         ABUSWIDTH'(REG_SIZE1):   reg_val = size[15:8];
         ABUSWIDTH'(REG_REP0):    reg_val = repeat_n[7:0];
         ABUSWIDTH'(REG_REP1):    reg_val = repeat_n[15:8];
         ABUSWIDTH'(REG_REP2):    reg_val = repeat_n[23:16];
         ABUSWIDTH'(REG_REP3):    reg_val = repeat_n[31:24];
         ABUSWIDTH'(REG_LSTART0): reg_val = loop_start[7:0];
         ABUSWIDTH'(REG_LSTART1): reg_val = loop_start[15:8];
         ABUSWIDTH'(REG_LSTOP0):  reg_val = loop_stop[7:0];
         ABUSWIDTH'(REG_LSTOP1):  reg_val = loop_stop[15:8];
         ABUSWIDTH'(REG_OUT_EN):  reg_val = out_en;
         ABUSWIDTH'(REG_IDLE):    reg_val = idle_level;
         default:                 reg_val = 8'd0;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (rst) begin
         conf <= '0; size <= '0; repeat_n <= 32'd1; loop_start <= '0; loop_stop <= '0;
         out_en <= 8'hFF; idle_level <= '0; done <= 1'b1;
         size_s <= '0; lstart_s <= '0; lstop_s <= '0; rep_s <= 32'd1; mode_s <= 1'b0; out_en_s <= '1;
         pos <= '0; pass <= '0; fetch_done <= 1'b1; rd_vld <= 1'b0; rd_loop <= 1'b0;
         CMD_START_FLAG <= 1'b0; CMD_LOOP_FLAG <= 1'b0; reg_rd <= '0; rd_sel_mem <= 1'b0;
      end else begin
         if (BUS_WR) begin
            case (BUS_ADD)
               ABUSWIDTH'(REG_CONF):    conf             <= BUS_DATA_IN;
               ABUSWIDTH'(REG_SIZE0):   size[7:0]        <= BUS_DATA_IN;
               ABUSWIDTH'(REG_SIZE1):   size[15:8]       <= BUS_DATA_IN;
               ABUSWIDTH'(REG_REP0):    repeat_n[7:0]    <= BUS_DATA_IN;
               ABUSWIDTH'(REG_REP1):    repeat_n[15:8]   <= BUS_DATA_IN;
               ABUSWIDTH'(REG_REP2):    repeat_n[23:16]  <= BUS_DATA_IN;
               ABUSWIDTH'(REG_REP3):    repeat_n[31:24]  <= BUS_DATA_IN;
               ABUSWIDTH'(REG_LSTART0): loop_start[7:0]  <= BUS_DATA_IN;
               ABUSWIDTH'(REG_LSTART1): loop_start[15:8] <= BUS_DATA_IN;
               ABUSWIDTH'(REG_LSTOP0):  loop_stop[7:0]   <= BUS_DATA_IN;
               ABUSWIDTH'(REG_LSTOP1):  loop_stop[15:8]  <= BUS_DATA_IN;
               ABUSWIDTH'(REG_OUT_EN):  out_en           <= BUS_DATA_IN;
               ABUSWIDTH'(REG_IDLE):    idle_level       <= BUS_DATA_IN;
               default: ;
            endcase
         end

         if (abort)                done <= 1'b1;
         else if (start_ok)        done <= 1'b0;
         else if (load && !rd_vld) done <= 1'b1;

         if (start_ok) begin
            size_s <= size; lstart_s <= loop_start; lstop_s <= loop_stop; rep_s <= repeat_n;
            mode_s <= conf[1]; out_en_s <= out_en[CHANNELS-1:0];
            pos <= '0; pass <= '0; fetch_done <= 1'b0;
         end

         // Prefetch runs one step ahead of the output stage; rd_vld low at a load marks the end of the run.
         if (fetch_en) begin
            rd_vld <= !fetch_done;
            if (!fetch_done) begin
               rd_loop <= loop_ok && (pos == lstart_s);
               if (wrap) begin
                  pos  <= lstart_s;
                  pass <= pass + 32'd1;
               end else if (pos == size_s - 16'd1) begin
                  fetch_done <= 1'b1;
               end else begin
                  pos <= pos + 16'd1;
               end
            end
         end

         CMD_START_FLAG <= load && !out_active && !conf[2] && !abort;
         CMD_LOOP_FLAG  <= load && rd_vld && rd_loop && !abort;

         if (BUS_RD) begin
            rd_sel_mem <= in_mem;
            reg_rd     <= reg_val;
         end
      end
   end

   cmd_seq_mc_out #(.CHANNELS(CHANNELS)) u_out (
      .clk        (BUS_CLK),
      .rst_n      (!rst),
      .clr        (abort),
      .load       (load),
      .load_vld   (rd_vld),
      .mode       (mode_s),
      .data       (rd_data),
      .out_en     (out_en_s),
      .idle_level (idle_level[CHANNELS-1:0]),
      .lanes      (CMD_DATA),
      .active     (out_active),
      .phase      (out_phase)
   );

   assign BUS_DATA_OUT         = rd_sel_mem ? mem_rd : reg_rd;
   assign CMD_READY            = (state == ST_IDLE);
   assign CMD_EXT_START_ENABLE = conf[0];
   assign dbg_state            = state;
endmodule

// File: tb/tb_cmd_seq_mc_core.sv
// Directed bench for cmd_seq_mc_core: bus-programmed patterns checked cycle by cycle against hand-built step lists.
module tb_cmd_seq_mc_core;
   import cmd_seq_mc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] add;
   logic [7:0]  din;
   logic        rd, wr;
   logic [7:0]  dout;
   logic        ext_start, abort_in;
   logic [3:0]  cmd_data;
   logic        ready, start_flag, loop_flag, ext_en;
   state_t      dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_q[$];
   logic       lf_q[$];

   always #5 clk = ~clk;

   cmd_seq_mc_core #(.ABUSWIDTH(16), .CHANNELS(4), .MEM_DEPTH(2048)) dut (
      .BUS_CLK              (clk),
      .BUS_RST_N            (rst_n),
      .BUS_ADD              (add),
      .BUS_DATA_IN          (din),
      .BUS_RD               (rd),
      .BUS_WR               (wr),
      .BUS_DATA_OUT         (dout),
      .CMD_EXT_START        (ext_start),
      .CMD_ABORT            (abort_in),
      .CMD_DATA             (cmd_data),
      .CMD_READY            (ready),
      .CMD_START_FLAG       (start_flag),
      .CMD_LOOP_FLAG        (loop_flag),
      .CMD_EXT_START_ENABLE (ext_en),
      .dbg_state            (dbg_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      add = a; din = d; wr = 1'b1;
      step_clk();
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a);
      add = a; rd = 1'b1;
      step_clk();
      rd = 1'b0;
   endtask

   task automatic write_mem(input int idx, input logic [7:0] d);
      bus_write(16'(MEM_BASE + idx), d);
   endtask

   // Plays exp_q/lf_q cycle by cycle; lead = edges to skip before step 0 is visible.
   task automatic play_check(input string tag, input int lead, input logic [3:0] idle, input logic sf_en);
      int n;
      n = exp_q.size();
      for (int i = 0; i < lead; i++) begin
         step_clk();
         check_eq({tag, " ready_fetch"}, ready, 0);
      end
      for (int k = 0; k < n; k++) begin
         step_clk();
         check_eq({tag, " data"},  cmd_data,   exp_q.pop_front());
         check_eq({tag, " loop"},  loop_flag,  lf_q.pop_front());
         check_eq({tag, " sflag"}, start_flag, (k == 0) && sf_en);
         check_eq({tag, " ready"}, ready,      0);
      end
      step_clk();
      check_eq({tag, " idle"},     cmd_data, idle);
      check_eq({tag, " ready_end"}, ready,   1);
   endtask

   initial begin
      int t2_steps[16];
      logic [3:0] e3;
      t2_steps = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 5, 6, 7, 8, 9};
      rst_n = 1'b0; add = '0; din = '0; rd = 1'b0; wr = 1'b0; ext_start = 1'b0; abort_in = 1'b0;
      repeat (3) step_clk();
      rst_n = 1'b1;
      check_eq("rst data",  cmd_data, 0);
      check_eq("rst ready", ready, 1);
      check_eq("rst sflag", start_flag, 0);
      check_eq("rst lflag", loop_flag, 0);
      check_eq("rst dout",  dout, 0);
      check_eq("rst state", dbg_state, ST_IDLE);

      // 1: SIZE=8, NRZ, no loop
      for (int i = 0; i < 8; i++) write_mem(i, 8'(i));
      bus_write(REG_SIZE0, 8);
      bus_write(REG_START, 0);
      for (int i = 0; i < 8; i++) begin exp_q.push_back(4'(i)); lf_q.push_back(1'b0); end
      play_check("t1", 1, 4'h0, 1'b1);
      bus_read(REG_START);
      check_eq("t1 done", dout, 1);

      // 2: SIZE=10, loop 2..5, REPEAT=3
      write_mem(8, 8); write_mem(9, 9);
      bus_write(REG_SIZE0, 10); bus_write(REG_REP0, 3);
      bus_write(REG_LSTART0, 2); bus_write(REG_LSTOP0, 5);
      bus_write(REG_START, 0);
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back(4'(t2_steps[i]));
         lf_q.push_back(t2_steps[i] == 2);
      end
      play_check("t2", 1, 4'h0, 1'b1);
      bus_read(REG_START);
      check_eq("t2 done", dout, 1);
      bus_read(REG_REP0);
      check_eq("t2 rep rd", dout, 3);

      // 3: REPEAT=0, loop 1..3, abort after 50 cycles
      write_mem(0, 5); write_mem(1, 6); write_mem(2, 7); write_mem(3, 8);
      bus_write(REG_SIZE0, 4); bus_write(REG_REP0, 0);
      bus_write(REG_LSTART0, 1); bus_write(REG_LSTOP0, 3);
      bus_write(REG_IDLE, 8'h0A);
      check_eq("t3 idle live", cmd_data, 4'hA);
      bus_write(REG_START, 0);
      step_clk();
      for (int k = 0; k < 50; k++) begin
         step_clk();
         if (k == 0) e3 = 4'd5;
         else e3 = ((k - 1) % 2 == 0) ? 4'd6 : 4'd7;
         check_eq("t3 data", cmd_data, e3);
         check_eq("t3 loop", loop_flag, (k >= 1) && ((k - 1) % 2 == 0));
      end
      bus_read(REG_START);
      check_eq("t3 busy", dout, 2);
      abort_in = 1'b1;
      step_clk();
      abort_in = 1'b0;
      check_eq("t3 abort ready", ready, 1);
      check_eq("t3 abort data", cmd_data, 4'hA);
      bus_read(REG_START);
      check_eq("t3 abort done", dout, 1);

      // 4: Manchester, lane 0 only; loop 1..3 with SIZE=2 is invalid so plays once
      write_mem(0, 8'h0F); write_mem(1, 8'h00);
      bus_write(REG_SIZE0, 2); bus_write(REG_CONF, 2);
      bus_write(REG_OUT_EN, 1); bus_write(REG_IDLE, 0);
      bus_write(REG_START, 0);
      exp_q = '{4'h0, 4'h1, 4'h1, 4'h0};
      lf_q  = '{1'b0, 1'b0, 1'b0, 1'b0};
      play_check("t4", 1, 4'h0, 1'b1);

      // 5: external start gating, mid-run start, start+abort
      write_mem(0, 3); write_mem(1, 9); write_mem(2, 12);
      bus_write(REG_SIZE0, 3); bus_write(REG_REP0, 1); bus_write(REG_LSTOP0, 5);
      bus_write(REG_CONF, 0); bus_write(REG_OUT_EN, 8'hFF);
      ext_start = 1'b1; step_clk(); ext_start = 1'b0;
      check_eq("t5 ext dis ready", ready, 1);
      check_eq("t5 ext_en 0", ext_en, 0);
      bus_write(REG_CONF, 1);
      check_eq("t5 ext_en 1", ext_en, 1);
      ext_start = 1'b1; step_clk(); ext_start = 1'b0;
      check_eq("t5 ext ready", ready, 0);
      check_eq("t5 state", dbg_state, ST_FETCH);
      bus_write(REG_START, 0);
      exp_q = '{4'h3, 4'h9, 4'hC};
      lf_q  = '{1'b0, 1'b0, 1'b0};
      play_check("t5", 0, 4'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step_clk();
         check_eq("t5 stays idle", ready, 1);
      end
      ext_start = 1'b1; abort_in = 1'b1;
      step_clk();
      ext_start = 1'b0; abort_in = 1'b0;
      check_eq("t5 start+abort", ready, 1);
      step_clk();
      check_eq("t5 start+abort 2", ready, 1);
      bus_read(REG_START);
      check_eq("t5 done", dout, 1);

      // 6: hard reset mid-run, register defaults, memory reads, SIZE=0, soft reset
      bus_write(REG_IDLE, 5);
      bus_write(REG_START, 0);
      repeat (3) step_clk();
      rst_n = 1'b0; step_clk(); rst_n = 1'b1;
      check_eq("t6 data",  cmd_data, 0);
      check_eq("t6 ready", ready, 1);
      check_eq("t6 sflag", start_flag, 0);
      check_eq("t6 lflag", loop_flag, 0);
      check_eq("t6 ext_en", ext_en, 0);
      check_eq("t6 dout",  dout, 0);
      bus_read(REG_RST);    check_eq("t6 version", dout, 2);
      bus_read(REG_START);  check_eq("t6 status",  dout, 1);
      bus_read(REG_CONF);   check_eq("t6 conf",    dout, 0);
      bus_read(REG_SIZE0);  check_eq("t6 size",    dout, 0);
      bus_read(REG_REP0);   check_eq("t6 rep0",    dout, 1);
      bus_read(REG_LSTOP0); check_eq("t6 lstop",   dout, 0);
      bus_read(REG_OUT_EN); check_eq("t6 out_en",  dout, 8'hFF);
      bus_read(REG_IDLE);   check_eq("t6 idle",    dout, 0);
      bus_read(16'(MEM_BASE + 1)); check_eq("t6 mem1", dout, 9);
      bus_read(16'(MEM_BASE + 2048)); check_eq("t6 mem oob", dout, 0);
      bus_write(REG_START, 0);
      check_eq("t6 size0 ready", ready, 1);
      bus_read(REG_START);  check_eq("t6 size0 done", dout, 1);
      bus_write(REG_IDLE, 6);
      check_eq("t6 idle6", cmd_data, 6);
      bus_write(REG_RST, 0);
      check_eq("t6 soft rst data", cmd_data, 0);
      bus_read(REG_IDLE);   check_eq("t6 soft rst idle", dout, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
